rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares a single resource between eight requesters and reports the owner both one-hot and as a 3-bit binary index. It is the sequencing front end for the 8-to-3 encoding path. Requests are one-hot per requester. The grant is registered and is held until the owner drops its request. An optional hold-timeout forcibly reclaims the resource.

## Interface
- HOLD_MAX, default 15: maximum consecutive GRANT cycles before a forced release; legal range 1..255. Used only when timeout is compiled in.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i asserted means requester i wants the resource; any number of bits may be high.
- gnt  output  8  one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of the owner: bit i → 3'd i; holds 3'd0 when gnt_vld=0.
- gnt_vld  output  1  high while an owner exists; equals |gnt.
- tmo  output  1  one-cycle pulse on a forced release; constant 0 when timeout is compiled out.

## Operation
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_idx=0, gnt_vld=0, tmo=0.
  - state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- The FSM has two states: IDLE and GRANT.
- IDLE:
  - If req==0, remain in IDLE with outputs zero.
  - Otherwise, at the clock edge, select the winner w = the first index with req set, searching ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Register gnt=1<<w, gnt_idx=w, gnt_vld=1, cnt=0, and go to GRANT.
- GRANT:
  - Grant outputs are stable for the whole tenure.
  - Requests from other requesters are ignored (no preemption).
  - Release condition: req[gnt_idx]==0 sampled at an edge, or a timeout.
  - On release, at that edge: gnt=0, gnt_vld=0, gnt_idx=0, ptr=(owner+1) mod 8 with 3-bit wrap (7→0), go to IDLE.
  - Otherwise stay in GRANT and set cnt=cnt+1, saturating at HOLD_MAX.
- Release rules:
  - Each release is followed by exactly one IDLE cycle before the next grant; the pointer update prevents the same requester from winning back-to-back while others wait.
  - A lone requester that re-requests wins again after the one IDLE cycle.
- Timeout (compiled in): in GRANT, if cnt==HOLD_MAX and req[owner] is still high, force a release at that edge and assert tmo for the following cycle only.
- Simultaneous owner-drop and timeout: treat as a normal release, tmo=0.
- Reset asserted mid-grant: outputs clear immediately; no pending state survives.

## Timing
- Request-to-grant latency: req seen high at edge k in IDLE → gnt valid after edge k, i.e. visible during cycle k+1.
- Release latency: req[owner] low at edge k → gnt=0 during cycle k+1; the earliest next grant is visible during cycle k+2.
- Maximum tenure with timeout: HOLD_MAX+1 GRANT cycles.
- All outputs are registered; there are no combinational paths from req to outputs.
- Fairness bound: a continuously requesting requester waits at most 7 tenures.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - The cnt register, timeout release and tmo pulse are built.
  - HOLD_MAX is honoured.
- RR_ARB_TIMEOUT_EN undefined:
  - No counter is built and tmo is tied 0.
  - An owner holds the grant indefinitely while its req stays high.

## Test plan
- Reset: assert rst_n=0 mid-grant with req=8'hFF → gnt, gnt_idx, gnt_vld and tmo go 0 immediately; after release, the first grant goes to requester 0.
- Single request: req=8'b0001_0000 from IDLE → gnt=8'h10, gnt_idx=3'd4, gnt_vld=1 one cycle later; drop req → gnt=0 the next cycle.
- Round robin: req=8'hFF held, each owner drops its req for one cycle after a 2-cycle tenure → grant order 0,1,2,…,7,0, with one IDLE cycle between grants.
- Wrap and skip: ptr=6, req=8'b0000_0101 → grant index 0, then index 2, then index 0 again.
- Timeout (RR_ARB_TIMEOUT_EN, HOLD_MAX=3): req=8'b1000_0001 held → requester 0 is granted for 4 cycles, tmo pulses 1 cycle, then requester 7 is granted.
- No-timeout build: req[3] held for 100 cycles → gnt=8'h08 throughout and tmo stays 0.

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master drives requests, and the slave (the arbiter) drives the grant view.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  modport master (output req, input gnt, gnt_idx, gnt_vld, tmo);
  modport slave  (input req, output gnt, gnt_idx, gnt_vld, tmo);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a registered grant that is held until the owner drops req.
// req->gnt takes 1 cycle, and there is one IDLE cycle between tenures. The optional hold timeout is built under RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [7:0] r_gnt,   w_gnt_nxt;
  logic [2:0] r_idx,   w_idx_nxt;
  logic [2:0] w_win;
  logic       w_found;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] L_HOLD = 8'(HOLD_MAX);
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_tmo, w_tmo_nxt;
`endif

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
      $error("rr_arbiter8: HOLD_MAX must be in 1..255");
    end
  endgenerate

  // First requester at or after the pointer, wrapping modulo 8
  always_comb begin : p_search
    logic [2:0] cand;
    w_win   = '0;
    w_found = 1'b0;
    cand    = '0;
    for (int i = 0; i < 8; i++) begin
      cand = r_ptr + 3'(i);
      if (!w_found && arb.req[cand]) begin
        w_win   = cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
`ifdef RR_ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 8'b1 << w_win;
          w_idx_nxt   = w_win;
`ifdef RR_ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        // An owner drop wins over a coincident timeout, so tmo stays low in that case
        if (!arb.req[r_idx]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_ptr_nxt   = r_idx + 3'd1;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (r_cnt == L_HOLD) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_ptr_nxt   = r_idx + 3'd1;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_idx   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
`endif
    end
  end

  assign arb.gnt     = r_gnt;
  assign arb.gnt_idx = r_idx;
  assign arb.gnt_vld = |r_gnt;
`ifdef RR_ARB_TIMEOUT_EN
  assign arb.tmo     = r_tmo;
`else
  assign arb.tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8; the observation word is {gnt, gnt_idx, gnt_vld, tmo}.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter8;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 15;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] act;
    bus.req = 8'h00;
    rst_n   = 1'b0;
    #12;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL reset_idle: got %h want %h", act, 13'h0); end
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h01, 3'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL reset_grant0: got %h want %h", act, {8'h01, 3'd0, 1'b1, 1'b0}); end
    tick;
    rst_n = 1'b0;
    #1;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL reset_mid_grant: got %h want %h", act, 13'h0); end
    rst_n = 1'b1;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h01, 3'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL reset_first_after: got %h want %h", act, {8'h01, 3'd0, 1'b1, 1'b0}); end
    bus.req = 8'h00;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL reset_release: got %h want %h", act, 13'h0); end
    tick;
  endtask

  // The pointer is 1 here (the last owner was 0), so a lone request from 4 wins
  task automatic test_single;
    logic [12:0] act;
    bus.req = 8'b0001_0000;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h10, 3'd4, 1'b1, 1'b0}) begin n_bad++; $display("FAIL single_grant: got %h want %h", act, {8'h10, 3'd4, 1'b1, 1'b0}); end
    bus.req = 8'h00;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL single_release: got %h want %h", act, 13'h0); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [12:0] act;
    logic [12:0] exp;
    logic [7:0]  eg;
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      eg  = 8'b1 << (k % 8);
      exp = {eg, 3'(k % 8), 1'b1, 1'b0};
      tick;
      act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      n_cmp++; if (act !== exp) begin n_bad++; $display("FAIL rr_grant k=%0d: got %h want %h", k, act, exp); end
      tick;
      act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      n_cmp++; if (act !== exp) begin n_bad++; $display("FAIL rr_hold k=%0d: got %h want %h", k, act, exp); end
      bus.req = 8'hFF & ~eg;
      tick;
      act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL rr_idle k=%0d: got %h want %h", k, act, 13'h0); end
      bus.req = 8'hFF;
    end
    bus.req = 8'h00;
    tick;
    tick;
  endtask

  task automatic test_wrap_skip;
    logic [12:0] act;
    // The pointer is 1 after round robin. Grant and release 5 to move the pointer to 6.
    bus.req = 8'b0010_0000;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h20, 3'd5, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_setup: got %h want %h", act, {8'h20, 3'd5, 1'b1, 1'b0}); end
    bus.req = 8'h00;
    tick;
    bus.req = 8'b0000_0101;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h01, 3'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_first0: got %h want %h", act, {8'h01, 3'd0, 1'b1, 1'b0}); end
    bus.req = 8'b0000_0100;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL wrap_idle1: got %h want %h", act, 13'h0); end
    bus.req = 8'b0000_0101;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h04, 3'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_then2: got %h want %h", act, {8'h04, 3'd2, 1'b1, 1'b0}); end
    bus.req = 8'b0000_0001;
    tick;
    bus.req = 8'b0000_0101;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h01, 3'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_again0: got %h want %h", act, {8'h01, 3'd0, 1'b1, 1'b0}); end
    bus.req = 8'h00;
    tick;
    tick;
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [12:0] act;
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 8'b1000_0001;
    for (int c = 1; c <= 4; c++) begin
      tick;
      act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      n_cmp++; if (act !== {8'h01, 3'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL tmo_tenure c=%0d: got %h want %h", c, act, {8'h01, 3'd0, 1'b1, 1'b0}); end
    end
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h00, 3'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL tmo_pulse: got %h want %h", act, {8'h00, 3'd0, 1'b0, 1'b1}); end
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== {8'h80, 3'd7, 1'b1, 1'b0}) begin n_bad++; $display("FAIL tmo_next7: got %h want %h", act, {8'h80, 3'd7, 1'b1, 1'b0}); end
    // Owner 7 drops on the same edge its count reaches the limit, so this is a plain release
    tick;
    tick;
    tick;
    bus.req = 8'b0000_0001;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL tmo_coincident_drop: got %h want %h", act, 13'h0); end
    bus.req = 8'h00;
    tick;
    tick;
  endtask
`else
  task automatic test_no_timeout;
    logic [12:0] act;
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 8'b0000_1000;
    for (int c = 0; c < 100; c++) begin
      tick;
      act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      n_cmp++; if (act !== {8'h08, 3'd3, 1'b1, 1'b0}) begin n_bad++; $display("FAIL notmo_hold c=%0d: got %h want %h", c, act, {8'h08, 3'd3, 1'b1, 1'b0}); end
    end
    bus.req = 8'h00;
    tick;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
    n_cmp++; if (act !== 13'h0) begin n_bad++; $display("FAIL notmo_release: got %h want %h", act, 13'h0); end
    tick;
  endtask
`endif

  initial begin
    bus.req = 8'h00;
    test_reset;
    test_single;
    test_round_robin;
    test_wrap_skip;
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
